seg_scan_mux: RTL

Parametrised N-digit time-multiplexed seven-segment driver for score and status display. It takes packed BCD digits, per-digit decimal points and blink mask, and drives the shared segment bus and anode lines. It has an internal refresh prescaler, frame-coherent input snapshot (no tearing), leading-zero blanking, blink mode and a frame strobe. It replaces the hand-written 4-digit scan logic at the top level and sits between the score counter and the board pins.

---
 rtl/seg_scan_mux.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: N-digit multiplexed seven-segment scanner.
// Frame-coherent snapshot, leading-zero blanking, blink, frame strobe.
//
// Ports:
//   clk, rst (sync, active-low)
//   digits_bcd : packed codes, [3:0] is digit 0
//   dp_in      : decimal point request per digit
//   blink_mask : digits to blink
//   blank_lz   : leading-zero blanking enable
//   seg        : {g,f,e,d,c,b,a}
//   dp         : decimal point of selected digit
//   an         : one-hot anode select
//   frame_tick : pulse with the first slot of a frame
module seg_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits_bcd,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int   PW  = $clog2(REFRESH_DIV);
  localparam int   IW  = $clog2(DIGITS);
  localparam int   BW  = $clog2(BLINK_FRAMES + 1);
  localparam logic OFF = ACTIVE_LOW;

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] s_bcd;
  logic [DIGITS-1:0]   s_dp;
  logic [DIGITS-1:0]   s_mask;
  logic                s_lz;
  logic                phase;
  logic [BW-1:0]       bcnt;

  logic                tick;
  logic                frame_start;
  logic [IW-1:0]       nidx;
  logic [4*DIGITS-1:0] n_bcd;
  logic [DIGITS-1:0]   n_dp;
  logic [DIGITS-1:0]   n_mask;
  logic                n_lz;
  logic                n_phase;
  logic [BW-1:0]       n_bcnt;
  logic [DIGITS-1:0]   lz_blank;
  logic                run;
  logic [3:0]          code;
  logic                blink;
  logic [6:0]          seg_ah;
  logic                dp_ah;
  logic [DIGITS-1:0]   an_ah;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    unique case (c)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      4'd15:   glyph = 7'h00;
      default: glyph = 7'h40;
    endcase
  endfunction

  always_comb begin
    tick        = (presc == PW'(REFRESH_DIV - 1));
    nidx        = (idx == '0) ? IW'(DIGITS - 1) : idx - 1'b1;
    frame_start = tick && (idx == '0);

    // The first slot of a frame must use the values captured
    // on that same edge, so decode from the "next" snapshot.
    n_bcd  = frame_start ? digits_bcd : s_bcd;
    n_dp   = frame_start ? dp_in      : s_dp;
    n_mask = frame_start ? blink_mask : s_mask;
    n_lz   = frame_start ? blank_lz   : s_lz;

    // bcnt = frame starts seen in the current phase; the toggle
    // lands on the frame start that opens the next half-period.
    n_phase = phase;
    n_bcnt  = bcnt;
    if (frame_start) begin
      if (bcnt == BW'(BLINK_FRAMES)) begin
        n_bcnt  = BW'(1);
        n_phase = ~phase;
      end else begin
        n_bcnt = bcnt + 1'b1;
      end
    end

    run      = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run         = run && (n_bcd[4*i +: 4] == 4'd0);
      lz_blank[i] = n_lz && run && (i != 0);
    end

    code  = n_bcd[{nidx, 2'b00} +: 4];
    blink = n_phase && n_mask[nidx];
    if (blink || code == 4'd15 || lz_blank[nidx])
      seg_ah = 7'h00;
    else
      seg_ah = glyph(code);
    dp_ah = !blink && n_dp[nidx];
    an_ah = DIGITS'(1) << nidx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc      <= '0;
      idx        <= '0;
      s_bcd      <= '1;
      s_dp       <= '0;
      s_mask     <= '0;
      s_lz       <= 1'b0;
      phase      <= 1'b0;
      bcnt       <= '0;
      seg        <= {7{OFF}};
      dp         <= OFF;
      an         <= {DIGITS{OFF}};
      frame_tick <= 1'b0;
    end else begin
      presc      <= tick ? '0 : presc + 1'b1;
      frame_tick <= frame_start;
      s_bcd      <= n_bcd;
      s_dp       <= n_dp;
      s_mask     <= n_mask;
      s_lz       <= n_lz;
      phase      <= n_phase;
      bcnt       <= n_bcnt;
      if (tick) begin
        idx <= nidx;
        seg <= seg_ah ^ {7{OFF}};
        dp  <= dp_ah ^ OFF;
        an  <= an_ah ^ {DIGITS{OFF}};
      end
    end
  end

endmodule
